// File: rtl/uart_rx_mmio_pkg.sv
// uart_rx_mmio_pkg
//  Shared constants for the memory-mapped UART receiver: register offsets,
//  deframer state encodings (exposed on the debug port), RXSTAT bit
//  positions and a parity helper.
//  Optional feature macro: UART_RX_PARITY_EN (even parity bit after DATA).
package uart_rx_mmio_pkg;

  // Register offsets decoded from addr[3:0]
  localparam logic [3:0] UART_RX_DATA_OFS = 4'h4;
  localparam logic [3:0] UART_RX_STAT_OFS = 4'h5;

  // Deframer state encodings (3-bit)
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  // RXSTAT bit positions
  localparam int STAT_NEMPTY  = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVR     = 2;
  localparam int STAT_FERR    = 3;
  localparam int STAT_PERR    = 4;
  localparam int STAT_CNT_LSB = 8;

  // High when data plus received parity bit do not have even parity.
  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//  Synchronous FIFO holding received bytes until the CPU pops them.
//  Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write request and data
//   pop, dout    read request and head-of-queue data (dout valid when !empty)
//   empty, full  occupancy flags
//   count        number of stored entries, 0..DEPTH
//  Handshake: push is accepted when !full or when an accepted pop happens on
//  the same clk; pop is accepted only when !empty. Requests that are not
//  accepted are dropped with no state change.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
//  Memory-mapped UART receiver. Oversamples uart_rxd at 16x baud, deframes
//  8N1 bytes (8E1 when UART_RX_PARITY_EN is defined) and queues them in a
//  FIFO for the CPU.
//  Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             device select from the bus decoder
//   write_enable   bus write strobes, bit[2] = word write
//   addr           byte address, addr[3:0] decoded (0x4 RXDATA, 0x5 RXSTAT)
//   data_in        write data (RXSTAT W1C on bits [4:2])
//   data_out       combinational read data, high-Z when not selected/unmapped
//   uart_rxd       asynchronous serial input, idle high
//   rx_irq         FIFO non-empty or any sticky error flag set
//   dbg_state      current deframer state
//  Optional feature macro: UART_RX_PARITY_EN.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int BAUD_INC   = 858992,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  write_enable,
  input  logic [23:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        uart_rxd,
  output logic        rx_irq,
  output logic [2:0]  dbg_state
);

  localparam int          CW  = $clog2(FIFO_DEPTH+1);
  localparam logic [28:0] INC = 29'(BAUD_INC);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0]  AFTER_DATA = RX_PARITY;
`else
  localparam logic [2:0]  AFTER_DATA = RX_STOP;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  logic rx_meta, rxs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  // Phase accumulator: tick is the carry out of bit 27 of acc + INC.
  logic [27:0] acc;
  logic [28:0] acc_sum;
  logic        tick;
  assign acc_sum = {1'b0, acc} + INC;
  assign tick    = acc_sum[28];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc_sum[27:0];
  end

  // Deframer
  logic [2:0] state;
  logic [3:0] tcnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic       sample_pt;
  logic       stop_sample;
  logic       par_bad;
  logic       perr_set;

  // DATA/PARITY/STOP sample on the 16th tick; tcnt 15 -> 0 wraps naturally.
  assign sample_pt   = tick & (tcnt == 4'd15);
  assign stop_sample = (state == RX_STOP) & sample_pt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RX_IDLE;
      tcnt  <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else if (tick) begin
      tcnt <= tcnt + 4'd1;
      case (state)
        RX_IDLE: begin
          tcnt <= '0;
          if (!rxs) state <= RX_START;
        end
        RX_START: begin
          if (tcnt == 4'd7) begin
            tcnt  <= '0;
            bidx  <= '0;
            state <= rxs ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (tcnt == 4'd15) begin
            shreg <= {rxs, shreg[7:1]};
            bidx  <= bidx + 3'd1;
            if (bidx == 3'd7) state <= AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: if (tcnt == 4'd15) state <= RX_STOP;
`else
        RX_PARITY: state <= RX_IDLE;
`endif
        RX_STOP:   if (tcnt == 4'd15) state <= RX_IDLE;
        default:   state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  // Remembers a parity mismatch so the following stop sample drops the byte.
  assign perr_set = (state == RX_PARITY) & sample_pt & parity_bad(shreg, rxs);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   par_bad <= 1'b0;
    else if (tick & (state == RX_IDLE) & ~rxs)    par_bad <= 1'b0;
    else if (perr_set)                            par_bad <= 1'b1;
  end
`else
  assign perr_set = 1'b0;
  assign par_bad  = 1'b0;
`endif

  // Bus decode
  logic wr_word, pop_req, w1c, push, ovr_set, ferr_set;
  logic fifo_empty, fifo_full;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [4:0]    cnt5;

  assign wr_word  = en & write_enable[2];
  assign pop_req  = wr_word & (addr[3:0] == UART_RX_DATA_OFS);
  assign w1c      = wr_word & (addr[3:0] == UART_RX_STAT_OFS);
  assign push     = stop_sample & rxs & ~par_bad;
  // A pop on the same clk frees the slot, so a full FIFO is not an overrun.
  assign ovr_set  = push & fifo_full & ~(pop_req & ~fifo_empty);
  assign ferr_set = stop_sample & ~rxs;
  assign cnt5     = 5'(fifo_count);

  uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shreg),
    .pop   (pop_req),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Sticky error flags: a set on the same clk as a W1C clear wins.
  logic ovr, ferr, perr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~(w1c & data_in[2]));
      ferr <= ferr_set | (ferr & ~(w1c & data_in[3]));
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr <= 1'b0;
    else        perr <= perr_set | (perr & ~(w1c & data_in[4]));
  end
  logic unused_bits;
  assign unused_bits = ^{addr[23:4], data_in[31:5], data_in[1:0],
                         write_enable[1:0], cnt5[4]};
`else
  assign perr = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{addr[23:4], data_in[31:4], data_in[1:0],
                         write_enable[1:0], cnt5[4], perr_set};
`endif

  assign rx_irq    = ~fifo_empty | ovr | ferr | perr;
  assign dbg_state = state;

  // Read mux
  logic        rd_hit;
  logic [31:0] rd_val;
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    if (addr[3:0] == UART_RX_DATA_OFS) begin
      rd_hit = 1'b1;
      rd_val = {24'b0, (fifo_empty ? 8'h00 : fifo_dout)};
    end else if (addr[3:0] == UART_RX_STAT_OFS) begin
      rd_hit                        = 1'b1;
      rd_val[STAT_NEMPTY]           = ~fifo_empty;
      rd_val[STAT_FULL]             = fifo_full;
      rd_val[STAT_OVR]              = ovr;
      rd_val[STAT_FERR]             = ferr;
      rd_val[STAT_PERR]             = perr;
      rd_val[STAT_CNT_LSB +: 4]     = cnt5[3:0];
    end
  end

  assign data_out = (en & rd_hit) ? rd_val : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio
//  Self-checking bench for uart_rx_mmio with BAUD_INC = 2^24 (one tick per
//  16 clk, one bit per 256 clk). The expected state is a byte queue plus
//  three sticky flags, updated per received frame and per bus write.
//  Honours UART_RX_PARITY_EN for frame format and the parity case.
module tb_uart_rx_mmio;
  import uart_rx_mmio_pkg::*;

  localparam int BIT_CLK = 256;
  localparam int DEPTH   = 8;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [2:0]  write_enable;
  logic [23:0] addr;
  logic [31:0] data_in;
  wire  [31:0] data_out;
  logic        uart_rxd;
  logic        rx_irq;
  logic [2:0]  dbg_state;

  uart_rx_mmio #(.BAUD_INC(1 << 24), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .write_enable (write_enable),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .uart_rxd     (uart_rxd),
    .rx_irq       (rx_irq),
    .dbg_state    (dbg_state)
  );

  // Scoreboard: expected FIFO contents and sticky flags
  logic [7:0] exp_q[$];
  bit m_ovr, m_ferr, m_perr;
  bit chk_en = 1'b0;
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] exp_stat();
    logic [31:0] s;
    s = 32'd0;
    s[0]    = (exp_q.size() != 0);
    s[1]    = (exp_q.size() == DEPTH);
    s[2]    = m_ovr;
    s[3]    = m_ferr;
    s[4]    = m_perr;
    s[11:8] = 4'(exp_q.size());
    return s;
  endfunction

  function automatic logic exp_irq();
    return (exp_q.size() != 0) || m_ovr || m_ferr || m_perr;
  endfunction

  function automatic logic good_par(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic check32(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", name, got, exp, $time);
    end
  endtask

  // Interrupt line compared every cycle while no frame is in flight.
  always @(negedge clk) begin
    if (chk_en) check32("rx_irq_cycle", {31'b0, rx_irq}, {31'b0, exp_irq()});
  end

  // Driver tasks
  task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    en = 1'b1; write_enable = 3'b000; addr = {20'b0, a};
    #1 v = data_out;
    en = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; write_enable = 3'b100; addr = {20'b0, a}; data_in = d;
    @(posedge clk);
    if (a == 4'h4 && exp_q.size() != 0) void'(exp_q.pop_front());
    if (a == 4'h5) begin
      if (d[2]) m_ovr  = 1'b0;
      if (d[3]) m_ferr = 1'b0;
      if (d[4]) m_perr = 1'b0;
    end
    #1;
    en = 1'b0; write_enable = 3'b000; addr = '0; data_in = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = par;
    repeat (BIT_CLK) @(negedge clk);
`else
    if (par) uart_rxd = 1'b1;
`endif
    uart_rxd = stop_bit;
    repeat (BIT_CLK) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit,
                             input logic par);
    bit pbad;
    pbad = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad = (par != ^b);
    if (pbad) m_perr = 1'b1;
`else
    if (par) pbad = 1'b0;
`endif
    if (!stop_bit) m_ferr = 1'b1;
    else if (!pbad) begin
      if (exp_q.size() == DEPTH) m_ovr = 1'b1;
      else exp_q.push_back(b);
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_bit,
                       input logic par, input int gap);
    chk_en = 1'b0;
    send_frame(b, stop_bit, par);
    model_frame(b, stop_bit, par);
    chk_en = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    bus_read(4'h5, v);
    check32({tag, ".stat"}, v, exp_stat());
    bus_read(4'h4, v);
    check32({tag, ".data"}, v, (exp_q.size() != 0) ? {24'b0, exp_q[0]} : 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  logic [31:0] rv;
  logic [7:0]  rb;
  logic [7:0]  exp_seq [8];
  initial begin
    rst_n = 1'b0; en = 1'b0; write_enable = '0; addr = '0; data_in = '0;
    uart_rxd = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    bus_read(4'h5, rv);
    check32("reset.stat", rv, 32'h0);
    check32("reset.irq", {31'b0, rx_irq}, 32'h0);
    check32("reset.state", {29'b0, dbg_state}, {29'b0, RX_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (40) @(negedge clk);

    // 1: single byte, then pop
    frame(8'hA5, 1'b1, good_par(8'hA5), 80);
    bus_read(4'h5, rv);  check32("t1.stat_lit", rv, 32'h0000_0101);
    bus_read(4'h4, rv);  check32("t1.data_lit", rv, 32'h0000_00A5);
    check32("t1.irq_lit", {31'b0, rx_irq}, 32'h1);
    bus_write(4'h4, 32'h0);
    bus_read(4'h5, rv);  check32("t1.stat_pop", rv, 32'h0);
    check32("t1.irq_pop", {31'b0, rx_irq}, 32'h0);

    // 2: short low glitch is rejected
    chk_en = 1'b0;
    @(negedge clk); uart_rxd = 1'b0;
    repeat (64) @(negedge clk); uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk_en = 1'b1;
    bus_read(4'h5, rv);  check32("t2.stat_lit", rv, 32'h0);
    check32("t2.state", {29'b0, dbg_state}, {29'b0, RX_IDLE});

    // 3: nine bytes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b1, good_par(8'(i)), 70);
    bus_read(4'h5, rv);  check32("t3.stat_lit", rv, 32'h0000_0807);
    bus_read(4'h4, rv);  check32("t3.head_lit", rv, 32'h0000_0001);
    check_all("t3");

    // 5: pop on the same clk as the stop-bit sample of a frame into a full FIFO
    bus_write(4'h5, 32'h4);
    bus_read(4'h5, rv);  check32("t5.pre_stat", rv, 32'h0000_0803);
    chk_en = 1'b0;
    fork
      send_frame(8'h0A, 1'b1, good_par(8'h0A));
      begin : popper
        int n;
        bit found;
        n = 0; found = 1'b0;
        while (!found && n < 4000) begin
          @(negedge clk);
          if (dbg_state == RX_STOP) found = 1'b1;
          n++;
        end
        checks++;
        if (!found) begin
          failures++;
          $display("FAIL t5.stop_wait got=timeout exp=RX_STOP");
        end else begin
          repeat (BIT_CLK - 1) @(posedge clk);
          @(negedge clk);
          en = 1'b1; write_enable = 3'b100; addr = 24'h4;
          @(posedge clk);
          #1 en = 1'b0; write_enable = 3'b000; addr = '0;
        end
      end
    join
    void'(exp_q.pop_front());
    model_frame(8'h0A, 1'b1, good_par(8'h0A));
    chk_en = 1'b1;
    repeat (70) @(negedge clk);
    bus_read(4'h5, rv);  check32("t5.stat_lit", rv, 32'h0000_0803);
    check_all("t5");
    exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    for (int i = 0; i < 8; i++) begin
      bus_read(4'h4, rv);
      check32("t5.pop_seq", rv, {24'b0, exp_seq[i]});
      bus_write(4'h4, 32'h0);
    end
    check_all("t5.end");

    // 4: framing error and W1C
    frame(8'h3C, 1'b0, good_par(8'h3C), 120);
    bus_read(4'h5, rv);  check32("t4.stat_lit", rv, 32'h0000_0008);
    check32("t4.irq_lit", {31'b0, rx_irq}, 32'h1);
    bus_write(4'h5, 32'h8);
    bus_read(4'h5, rv);  check32("t4.stat_clr", rv, 32'h0);
    check32("t4.irq_clr", {31'b0, rx_irq}, 32'h0);

`ifdef UART_RX_PARITY_EN
    // parity mismatch drops the byte
    frame(8'h07, 1'b1, 1'b0, 80);
    bus_read(4'h5, rv);  check32("tp.stat_lit", rv, 32'h0000_0010);
    bus_write(4'h5, 32'h10);
    check_all("tp");
`endif

    // 6: reset mid-frame
    frame(8'h11, 1'b1, good_par(8'h11), 70);
    chk_en = 1'b0;
    fork
      send_frame(8'hFF, 1'b1, good_par(8'hFF));
      begin
        repeat (BIT_CLK * 4) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    model_reset();
    chk_en = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(4'h5, rv);  check32("t6.stat_lit", rv, 32'h0);
    check32("t6.state", {29'b0, dbg_state}, {29'b0, RX_IDLE});
    frame(8'h5A, 1'b1, good_par(8'h5A), 70);
    bus_read(4'h4, rv);  check32("t6.data_lit", rv, 32'h0000_005A);
    check_all("t6");
    bus_write(4'h4, 32'h0);

    // Randomized frames, pops and W1C writes
    for (int k = 0; k < 10; k++) begin
      logic sb, pb;
      rb = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      pb = ($urandom_range(0, 7) != 0) ? good_par(rb) : ~good_par(rb);
      frame(rb, sb, pb, $urandom_range(64, 400));
      check_all("rnd.frame");
      if ($urandom_range(0, 2) == 0) bus_write(4'h4, 32'h0);
      if ($urandom_range(0, 3) == 0) bus_write(4'h5, 32'($urandom_range(0, 31)));
      check_all("rnd.bus");
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
